rv32_pipeline_ctrl: RTL and testbench

Pipeline sequencer for the rv32 in-order core. It tracks the instruction occupying each post-decode stage (execute, mem, writeback) and issues stall, flush and bubble control to fetch and decode. It resolves read-after-write hazards against the decode stage's source registers. On an illegal instruction it drains the pipeline and halts the core. It sits beside the decode stage and consumes that stage's register indices and legality flag.

---
 rtl/rv32_ctrl_pkg.sv | 39 +++
 rtl/rv32_pipeline_ctrl_if.sv | 60 ++++++
 rtl/rv32_hazard.sv | 58 +++++
 rtl/rv32_pipeline_ctrl.sv | 178 +++++++++++++++++
 tb/tb_rv32_pipeline_ctrl.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/rv32_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// rv32_ctrl_pkg
// Shared types for the rv32 pipeline sequencer: the sequencer state enum, the
// per-stage occupancy record carried by execute/mem/writeback, the operand
// forwarding-select encodings and a helper that matches a stage against a
// source register index.
// Optional feature macro used by the users of this package: RV32_FORWARDING_EN.
// -----------------------------------------------------------------------------
package rv32_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        HALT  = 2'd2
    } ctrl_state_e;

    // What the sequencer needs to know about the instruction held in a stage
    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       rd_write;
        logic       load;
    } stage_t;

    localparam stage_t STAGE_EMPTY = '{valid: 1'b0, rd: 5'd0, rd_write: 1'b0, load: 1'b0};

    // Operand source selects seen by the execute-stage operand muxes
    localparam logic [1:0] FWD_REGFILE = 2'd0;
    localparam logic [1:0] FWD_E       = 2'd1;
    localparam logic [1:0] FWD_M       = 2'd2;
    localparam logic [1:0] FWD_W       = 2'd3;

    // True when the stage will write the register decode wants to read.
    // x0 is hard-wired to zero, so it never matches.
    function automatic logic stage_writes_rs(input stage_t stage, input logic [4:0] rs);
        return stage.valid && stage.rd_write && (stage.rd == rs) && (rs != 5'd0);
    endfunction

endpackage

// File: rtl/rv32_pipeline_ctrl_if.sv
// -----------------------------------------------------------------------------
// rv32_pipeline_ctrl_if
// Signal bundle between the decode stage / pipeline datapath and the pipeline
// sequencer.
//   decode_* inputs : present/legal flags, rs1/rs2 indices and read enables,
//                     rd index and write enable, load flag
//   branch_taken_in : execute resolved a taken branch/jump
//   mem_busy_in     : mem stage waiting on the data bus
//   outputs         : fetch/decode stall, decode flush, E/M/W valids, halted
//   rs1/rs2_fwd_sel_out exist only when RV32_FORWARDING_EN is defined.
// Modports: slave = the sequencer, master = the datapath side driving it.
// -----------------------------------------------------------------------------
interface rv32_pipeline_ctrl_if;

    logic       decode_present_in;
    logic       decode_legal_in;
    logic [4:0] decode_rs1_in;
    logic [4:0] decode_rs2_in;
    logic       decode_rs1_read_in;
    logic       decode_rs2_read_in;
    logic [4:0] decode_rd_in;
    logic       decode_rd_write_in;
    logic       decode_load_in;
    logic       branch_taken_in;
    logic       mem_busy_in;
    logic       fetch_stall_out;
    logic       decode_stall_out;
    logic       decode_flush_out;
    logic       execute_valid_out;
    logic       mem_valid_out;
    logic       writeback_valid_out;
    logic       halted_out;
`ifdef RV32_FORWARDING_EN
    logic [1:0] rs1_fwd_sel_out;
    logic [1:0] rs2_fwd_sel_out;
`endif

    modport slave (
        input  decode_present_in, decode_legal_in, decode_rs1_in, decode_rs2_in,
               decode_rs1_read_in, decode_rs2_read_in, decode_rd_in,
               decode_rd_write_in, decode_load_in, branch_taken_in, mem_busy_in,
        output fetch_stall_out, decode_stall_out, decode_flush_out,
               execute_valid_out, mem_valid_out, writeback_valid_out, halted_out
`ifdef RV32_FORWARDING_EN
        , output rs1_fwd_sel_out, rs2_fwd_sel_out
`endif
    );

    modport master (
        output decode_present_in, decode_legal_in, decode_rs1_in, decode_rs2_in,
               decode_rs1_read_in, decode_rs2_read_in, decode_rd_in,
               decode_rd_write_in, decode_load_in, branch_taken_in, mem_busy_in,
        input  fetch_stall_out, decode_stall_out, decode_flush_out,
               execute_valid_out, mem_valid_out, writeback_valid_out, halted_out
`ifdef RV32_FORWARDING_EN
        , input rs1_fwd_sel_out, rs2_fwd_sel_out
`endif
    );

endinterface

// File: rtl/rv32_hazard.sv
// -----------------------------------------------------------------------------
// rv32_hazard
// Combinational read-after-write check of one decode source register against
// the execute, mem and writeback stage records.
//   rs, rs_read      : source index and "instruction really reads it"
//   e/m/w_stage      : stage records
//   hazard           : decode must stall for this operand
//   fwd_sel          : operand source, youngest matching stage (only when
//                      RV32_FORWARDING_EN is defined)
// Without forwarding any matching stage stalls; with forwarding only a load
// still in execute does, because its data is not available yet.
// -----------------------------------------------------------------------------
module rv32_hazard
    import rv32_ctrl_pkg::*;
(
    input  logic [4:0] rs,
    input  logic       rs_read,
    input  stage_t     e_stage,
    input  stage_t     m_stage,
    input  stage_t     w_stage,
    output logic       hazard
`ifdef RV32_FORWARDING_EN
    , output logic [1:0] fwd_sel
`endif
);

    logic match_e_s;
    logic match_m_s;
    logic match_w_s;
    logic unused_load_s;

    assign match_e_s = rs_read && stage_writes_rs(e_stage, rs);
    assign match_m_s = rs_read && stage_writes_rs(m_stage, rs);
    assign match_w_s = rs_read && stage_writes_rs(w_stage, rs);

`ifdef RV32_FORWARDING_EN
    assign unused_load_s = m_stage.load ^ w_stage.load;
    assign hazard        = match_e_s && e_stage.load;

    // Forward from the youngest producer so the newest value wins
    always_comb begin
        fwd_sel = FWD_REGFILE;
        if (match_e_s) begin
            fwd_sel = FWD_E;
        end else if (match_m_s) begin
            fwd_sel = FWD_M;
        end else if (match_w_s) begin
            fwd_sel = FWD_W;
        end else begin
            fwd_sel = FWD_REGFILE;
        end
    end
`else
    assign unused_load_s = e_stage.load ^ m_stage.load ^ w_stage.load;
    assign hazard        = match_e_s || match_m_s || match_w_s;
`endif

endmodule

// File: rtl/rv32_pipeline_ctrl.sv
// -----------------------------------------------------------------------------
// rv32_pipeline_ctrl
// Pipeline sequencer for the rv32 in-order core. Tracks the instructions in
// execute, mem and writeback, resolves RAW hazards for the decode stage and
// issues stall / flush / bubble control to fetch and decode. An illegal
// instruction drains the pipeline and halts the core until reset.
// Ports:
//   clk      core clock, all state on posedge
//   reset_n  asynchronous active-low reset
//   bus      rv32_pipeline_ctrl_if.slave (decode inputs, branch/mem status,
//            stall/flush/valid/halted outputs, optional forwarding selects)
// Optional feature macro: RV32_FORWARDING_EN (operand forwarding; only
// load-use against execute stalls, adds rs1/rs2_fwd_sel_out).
// -----------------------------------------------------------------------------
module rv32_pipeline_ctrl
    import rv32_ctrl_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset_n,
    rv32_pipeline_ctrl_if.slave  bus
);

    ctrl_state_e state_r;
    ctrl_state_e state_nxt_s;
    stage_t      e_r;
    stage_t      m_r;
    stage_t      w_r;
    stage_t      dec_stage_s;
    logic        rs1_read_s;
    logic        rs2_read_s;
    logic        rs1_hazard_s;
    logic        rs2_hazard_s;
    logic        hazard_s;
    logic        illegal_s;
    logic        freeze_s;
    logic        e_bubble_s;
    logic        fetch_stall_s;
    logic        decode_stall_s;
    logic        decode_flush_s;
    logic        halted_s;
`ifdef RV32_FORWARDING_EN
    logic [1:0]  rs1_fwd_sel_s;
    logic [1:0]  rs2_fwd_sel_s;
`endif

    // Only a present, legal instruction takes part in hazard checks; the
    // source fields of an illegal encoding are meaningless.
    assign rs1_read_s = bus.decode_present_in && bus.decode_legal_in && bus.decode_rs1_read_in;
    assign rs2_read_s = bus.decode_present_in && bus.decode_legal_in && bus.decode_rs2_read_in;
    assign illegal_s  = bus.decode_present_in && !bus.decode_legal_in;
    assign hazard_s   = rs1_hazard_s || rs2_hazard_s;

    assign dec_stage_s = '{valid:    bus.decode_present_in && bus.decode_legal_in,
                           rd:       bus.decode_rd_in,
                           rd_write: bus.decode_rd_write_in,
                           load:     bus.decode_load_in};

    rv32_hazard u_rs1_hazard (
        .rs      (bus.decode_rs1_in),
        .rs_read (rs1_read_s),
        .e_stage (e_r),
        .m_stage (m_r),
        .w_stage (w_r),
        .hazard  (rs1_hazard_s)
`ifdef RV32_FORWARDING_EN
        , .fwd_sel (rs1_fwd_sel_s)
`endif
    );

    rv32_hazard u_rs2_hazard (
        .rs      (bus.decode_rs2_in),
        .rs_read (rs2_read_s),
        .e_stage (e_r),
        .m_stage (m_r),
        .w_stage (w_r),
        .hazard  (rs2_hazard_s)
`ifdef RV32_FORWARDING_EN
        , .fwd_sel (rs2_fwd_sel_s)
`endif
    );

    // Priority resolution, next state and control outputs
    always_comb begin
        state_nxt_s    = state_r;
        freeze_s       = 1'b0;
        e_bubble_s     = 1'b0;
        fetch_stall_s  = 1'b0;
        decode_stall_s = 1'b0;
        decode_flush_s = 1'b0;
        halted_s       = 1'b0;
        case (state_r)
            RUN: begin
                if (bus.mem_busy_in) begin
                    freeze_s       = 1'b1;
                    fetch_stall_s  = 1'b1;
                    decode_stall_s = 1'b1;
                end else if (bus.branch_taken_in) begin
                    // Wins over hazard and illegal: decode is wrong-path anyway
                    decode_flush_s = 1'b1;
                    e_bubble_s     = 1'b1;
                end else if (hazard_s) begin
                    fetch_stall_s  = 1'b1;
                    decode_stall_s = 1'b1;
                    e_bubble_s     = 1'b1;
                end else if (illegal_s) begin
                    // Hold the illegal instruction in decode; it never enters E
                    fetch_stall_s  = 1'b1;
                    decode_stall_s = 1'b1;
                    e_bubble_s     = 1'b1;
                    state_nxt_s    = DRAIN;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            DRAIN: begin
                fetch_stall_s  = 1'b1;
                decode_stall_s = 1'b1;
                e_bubble_s     = 1'b1;
                freeze_s       = bus.mem_busy_in;
                if (!e_r.valid && !m_r.valid && !w_r.valid) begin
                    state_nxt_s = HALT;
                end else begin
                    state_nxt_s = DRAIN;
                end
            end
            HALT: begin
                fetch_stall_s  = 1'b1;
                decode_stall_s = 1'b1;
                e_bubble_s     = 1'b1;
                halted_s       = 1'b1;
                state_nxt_s    = HALT;
            end
            default: begin
                state_nxt_s = RUN;
                e_bubble_s  = 1'b1;
            end
        endcase
    end

    // Sequencer state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= RUN;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Stage registers: freeze (W bubbles), or advance with optional E bubble
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            e_r <= STAGE_EMPTY;
            m_r <= STAGE_EMPTY;
            w_r <= STAGE_EMPTY;
        end else if (freeze_s) begin
            w_r <= STAGE_EMPTY;
        end else begin
            w_r <= m_r;
            m_r <= e_r;
            e_r <= e_bubble_s ? STAGE_EMPTY : dec_stage_s;
        end
    end

    // Stall/flush are combinational from live inputs, so they are forced
    // quiet while reset is held rather than reacting to decode contents.
    assign bus.fetch_stall_out     = reset_n && fetch_stall_s;
    assign bus.decode_stall_out    = reset_n && decode_stall_s;
    assign bus.decode_flush_out    = reset_n && decode_flush_s;
    assign bus.halted_out          = halted_s;
    assign bus.execute_valid_out   = e_r.valid;
    assign bus.mem_valid_out       = m_r.valid;
    assign bus.writeback_valid_out = w_r.valid;
`ifdef RV32_FORWARDING_EN
    assign bus.rs1_fwd_sel_out = rs1_fwd_sel_s;
    assign bus.rs2_fwd_sel_out = rs2_fwd_sel_s;
`endif

endmodule

// File: tb/tb_rv32_pipeline_ctrl.sv
// -----------------------------------------------------------------------------
// tb_rv32_pipeline_ctrl
// Table-driven bench for rv32_pipeline_ctrl. Each table row is one cycle:
// decode contents, branch/mem status and the expected outputs
// {fetch_stall, decode_stall, flush, e_valid, m_valid, w_valid, halted}
// (plus forwarding selects when RV32_FORWARDING_EN is defined). Reset and
// reset-in-the-middle-of-drain are hand-written sequences.
// -----------------------------------------------------------------------------
module tb_rv32_pipeline_ctrl;

    logic clk;
    logic reset_n;

    rv32_pipeline_ctrl_if bus ();

    rv32_pipeline_ctrl dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       pres;
        logic       legal;
        logic [4:0] rs1;
        logic       rd1;
        logic [4:0] rs2;
        logic       rd2;
        logic [4:0] rd;
        logic       wr;
        logic       ld;
    } ins_t;

    typedef struct packed {
        ins_t       ins;
        logic       br;
        logic       busy;
        logic [6:0] exp_out;
        logic [1:0] f1;
        logic [1:0] f2;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    logic [6:0] obs;
    assign obs = {bus.fetch_stall_out, bus.decode_stall_out, bus.decode_flush_out,
                  bus.execute_valid_out, bus.mem_valid_out, bus.writeback_valid_out,
                  bus.halted_out};

    function automatic ins_t alu(input logic [4:0] rd, input logic [4:0] rs1, input logic r1,
                                 input logic [4:0] rs2, input logic r2);
        ins_t t;
        t.pres = 1'b1; t.legal = 1'b1;
        t.rs1 = rs1;   t.rd1 = r1;
        t.rs2 = rs2;   t.rd2 = r2;
        t.rd = rd;     t.wr = 1'b1; t.ld = 1'b0;
        return t;
    endfunction

    function automatic ins_t prod(input logic [4:0] rd);
        return alu(rd, 5'd0, 1'b0, 5'd0, 1'b0);
    endfunction

    function automatic ins_t lw(input logic [4:0] rd);
        ins_t t;
        t = alu(rd, 5'd0, 1'b1, 5'd0, 1'b0);
        t.ld = 1'b1;
        return t;
    endfunction

    function automatic ins_t nop();
        ins_t t;
        t = '0;
        return t;
    endfunction

    function automatic ins_t ill();
        ins_t t;
        t = '0;
        t.pres = 1'b1;
        return t;
    endfunction

    task automatic add(input ins_t i, input logic br, input logic busy, input logic [6:0] e,
                       input logic [1:0] f1, input logic [1:0] f2);
        vecs.push_back('{i, br, busy, e, f1, f2});
    endtask

    task automatic drive(input ins_t i, input logic br, input logic busy);
        bus.decode_present_in  = i.pres;
        bus.decode_legal_in    = i.legal;
        bus.decode_rs1_in      = i.rs1;
        bus.decode_rs1_read_in = i.rd1;
        bus.decode_rs2_in      = i.rs2;
        bus.decode_rs2_read_in = i.rd2;
        bus.decode_rd_in       = i.rd;
        bus.decode_rd_write_in = i.wr;
        bus.decode_load_in     = i.ld;
        bus.branch_taken_in    = br;
        bus.mem_busy_in        = busy;
    endtask

    task automatic check(input string name, input logic [6:0] got, input logic [6:0] want);
        n_checks++;
        if (got === want) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %b expected %b (fst,dst,flush,ev,mv,wv,halt)", name, got, want);
        end
    endtask

    task automatic check_sel(input string name, input logic [1:0] got, input logic [1:0] want);
        n_checks++;
        if (got === want) begin
            n_pass++;
        end else begin
            $display("FAIL %s: fwd_sel got %0d expected %0d", name, got, want);
        end
    endtask

    task automatic step(input ins_t i);
        @(negedge clk);
        drive(i, 1'b0, 1'b0);
    endtask

    initial begin
        // ---------------- table ----------------
        add(nop(), 1'b0, 1'b0, 7'b0000000, 2'd0, 2'd0);          // reset state
`ifdef RV32_FORWARDING_EN
        // load-use: one bubble, then forwarded from M
        add(lw(5'd5), 1'b0, 1'b0, 7'b0000000, 2'd0, 2'd0);
        add(alu(5'd6, 5'd5, 1'b1, 5'd0, 1'b0), 1'b0, 1'b0, 7'b1101000, 2'd1, 2'd0);
        add(alu(5'd6, 5'd5, 1'b1, 5'd0, 1'b0), 1'b0, 1'b0, 7'b0000100, 2'd2, 2'd0);
        add(nop(), 1'b0, 1'b0, 7'b0001010, 2'd0, 2'd0);
        add(nop(), 1'b0, 1'b0, 7'b0000100, 2'd0, 2'd0);
        add(nop(), 1'b0, 1'b0, 7'b0000010, 2'd0, 2'd0);
        // ALU results forwarded without stall, youngest producer wins
        add(prod(5'd7), 1'b0, 1'b0, 7'b0000000, 2'd0, 2'd0);
        add(prod(5'd7), 1'b0, 1'b0, 7'b0001000, 2'd0, 2'd0);
        add(alu(5'd9, 5'd0, 1'b0, 5'd7, 1'b1), 1'b0, 1'b0, 7'b0001100, 2'd0, 2'd1);
        add(alu(5'd0, 5'd7, 1'b1, 5'd9, 1'b1), 1'b0, 1'b0, 7'b0001110, 2'd2, 2'd1);
        add(nop(), 1'b0, 1'b0, 7'b0001110, 2'd0, 2'd0);
        add(nop(), 1'b0, 1'b0, 7'b0000110, 2'd0, 2'd0);
        add(nop(), 1'b0, 1'b0, 7'b0000010, 2'd0, 2'd0);
`else
        // ADD x5 then reader of x5: three stall cycles, then reader enters E
        add(prod(5'd5), 1'b0, 1'b0, 7'b0000000, 2'd0, 2'd0);
        add(alu(5'd6, 5'd5, 1'b1, 5'd0, 1'b0), 1'b0, 1'b0, 7'b1101000, 2'd0, 2'd0);
        add(alu(5'd6, 5'd5, 1'b1, 5'd0, 1'b0), 1'b0, 1'b0, 7'b1100100, 2'd0, 2'd0);
        add(alu(5'd6, 5'd5, 1'b1, 5'd0, 1'b0), 1'b0, 1'b0, 7'b1100010, 2'd0, 2'd0);
        add(alu(5'd6, 5'd5, 1'b1, 5'd0, 1'b0), 1'b0, 1'b0, 7'b0000000, 2'd0, 2'd0);
        add(nop(), 1'b0, 1'b0, 7'b0001000, 2'd0, 2'd0);
        add(nop(), 1'b0, 1'b0, 7'b0000100, 2'd0, 2'd0);
        add(nop(), 1'b0, 1'b0, 7'b0000010, 2'd0, 2'd0);
`endif
        // rd = x0 producer, reader of x0: no stall
        add(prod(5'd0), 1'b0, 1'b0, 7'b0000000, 2'd0, 2'd0);
        add(alu(5'd7, 5'd0, 1'b1, 5'd0, 1'b1), 1'b0, 1'b0, 7'b0001000, 2'd0, 2'd0);
        // branch and load-use hazard together: flush wins, no stall
        add(lw(5'd5), 1'b0, 1'b0, 7'b0001100, 2'd0, 2'd0);
        add(alu(5'd6, 5'd5, 1'b1, 5'd0, 1'b0), 1'b1, 1'b0, 7'b0011110, 2'd1, 2'd0);
        add(nop(), 1'b0, 1'b0, 7'b0000110, 2'd0, 2'd0);
        add(nop(), 1'b0, 1'b0, 7'b0000010, 2'd0, 2'd0);
        // branch with illegal decode: flushed, stays in RUN
        add(prod(5'd8), 1'b0, 1'b0, 7'b0000000, 2'd0, 2'd0);
        add(ill(), 1'b1, 1'b0, 7'b0011000, 2'd0, 2'd0);
        add(prod(5'd9), 1'b0, 1'b0, 7'b0000100, 2'd0, 2'd0);
        add(prod(5'd10), 1'b0, 1'b0, 7'b0001010, 2'd0, 2'd0);
        add(prod(5'd11), 1'b0, 1'b0, 7'b0001100, 2'd0, 2'd0);
        // mem_busy for 4 cycles with E/M/W full
        add(prod(5'd12), 1'b0, 1'b1, 7'b1101110, 2'd0, 2'd0);
        add(prod(5'd12), 1'b0, 1'b1, 7'b1101100, 2'd0, 2'd0);
        add(prod(5'd12), 1'b0, 1'b1, 7'b1101100, 2'd0, 2'd0);
        add(prod(5'd12), 1'b0, 1'b1, 7'b1101100, 2'd0, 2'd0);
        add(prod(5'd12), 1'b0, 1'b0, 7'b0001100, 2'd0, 2'd0);
        add(prod(5'd13), 1'b0, 1'b0, 7'b0001110, 2'd0, 2'd0);
        // illegal with E/M/W full: 3 drain cycles, then halt
        add(ill(), 1'b0, 1'b0, 7'b1101110, 2'd0, 2'd0);
        add(ill(), 1'b0, 1'b0, 7'b1100110, 2'd0, 2'd0);
        add(ill(), 1'b0, 1'b0, 7'b1100010, 2'd0, 2'd0);
        add(ill(), 1'b0, 1'b0, 7'b1100000, 2'd0, 2'd0);
        add(ill(), 1'b0, 1'b0, 7'b1100001, 2'd0, 2'd0);
        add(prod(5'd14), 1'b0, 1'b0, 7'b1100001, 2'd0, 2'd0);

        // ---------------- reset ----------------
        reset_n = 1'b0;
        drive(ill(), 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        check("reset_outputs", obs, 7'b0000000);
        drive(nop(), 1'b0, 1'b0);
        reset_n = 1'b1;

        // ---------------- table loop ----------------
        for (int k = 0; k < vecs.size(); k++) begin
            @(negedge clk);
            drive(vecs[k].ins, vecs[k].br, vecs[k].busy);
            #1;
            check($sformatf("row%0d", k), obs, vecs[k].exp_out);
`ifdef RV32_FORWARDING_EN
            check_sel($sformatf("row%0d_rs1", k), bus.rs1_fwd_sel_out, vecs[k].f1);
            check_sel($sformatf("row%0d_rs2", k), bus.rs2_fwd_sel_out, vecs[k].f2);
`endif
        end

        // ---------------- reset in the middle of DRAIN ----------------
        @(negedge clk);
        reset_n = 1'b0;
        drive(nop(), 1'b0, 1'b0);
        #1;
        check("halt_reset", obs, 7'b0000000);
        @(negedge clk);
        reset_n = 1'b1;
        step(prod(5'd1));
        step(prod(5'd2));
        step(prod(5'd3));
        step(ill());
        #1;
        check("drain_entry", obs, 7'b1101110);
        @(negedge clk);
        #1;
        check("drain_cycle1", obs, 7'b1100110);
        #2;
        reset_n = 1'b0;
        #1;
        check("reset_mid_drain", obs, 7'b0000000);
        @(negedge clk);
        drive(prod(5'd4), 1'b0, 1'b0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check("first_after_reset", obs, 7'b0001000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
